conv_compute: RTL

Convolution engine directly downstream of the input-memory stage. Once `inputs_loaded` is high, it walks every valid output position of the R×C input X with the K×K kernel W using a single multiply-accumulate lane on read port 0. It streams each signed result out on an AXI-Stream master, then pulses `compute_finished` so the memory stage can accept the next job.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/output_fifo.sv | 53 +++++
 rtl/conv_compute.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and default sizing for the convolution engine.
package conv_pkg;

    localparam int CONV_INW       = 10;
    localparam int CONV_OUTW      = 32;
    localparam int CONV_R         = 15;
    localparam int CONV_C         = 13;
    localparam int CONV_MAXK      = 7;
    localparam int CONV_OUT_DEPTH = 4;

    localparam int KW  = $clog2(CONV_MAXK + 1);
    localparam int XAW = $clog2(CONV_R * CONV_C);
    localparam int WAW = $clog2(CONV_MAXK * CONV_MAXK);

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        PUSH,
        WAIT,
        FINISH
    } conv_state_t;

endpackage

// File: rtl/output_fifo.sv
// Small synchronous FIFO holding results until the stream consumer takes them.
module output_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr     = push & ~full;
    assign w_rd     = pop & ~empty;
    assign full     = (r_count == CW'(DEPTH));
    assign empty    = (r_count == '0);
    // Head is masked so the stream data reads zero whenever nothing is queued.
    assign data_out = empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_rd) r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/conv_compute.sv
// Single-lane convolution engine: walks every valid KxK window of X, one MAC per
// cycle, and streams each biased sum out through a small FIFO on AXI-Stream.
module conv_compute
    import conv_pkg::*;
#(
    parameter int INW       = CONV_INW,
    parameter int OUTW      = CONV_OUTW,
    parameter int R         = CONV_R,
    parameter int C         = CONV_C,
    parameter int MAXK      = CONV_MAXK,
    parameter int OUT_DEPTH = CONV_OUT_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            inputs_loaded,
    input  logic [$clog2(MAXK+1)-1:0]       K,
    input  logic signed [INW-1:0]           B,
    output logic [$clog2(R*C)-1:0]          X_read_addr,
    input  logic signed [INW-1:0]           X_data,
    output logic [$clog2(MAXK*MAXK)-1:0]    W_read_addr,
    input  logic signed [INW-1:0]           W_data,
    output logic                            compute_finished,
    output logic [OUTW-1:0]                 OUT_AXIS_TDATA,
    output logic                            OUT_AXIS_TVALID,
    output logic                            OUT_AXIS_TLAST,
    input  logic                            OUT_AXIS_TREADY
);

    localparam int KB    = $clog2(MAXK + 1);
    localparam int XA    = $clog2(R * C);
    localparam int WA    = $clog2(MAXK * MAXK);
    localparam int RB    = $clog2(R + 1);
    localparam int CB    = $clog2(C + 1);
    localparam int PW    = 2 * INW;
    localparam int MINRC = (R < C) ? R : C;

    conv_state_t             r_state;
    conv_state_t             w_next;
    logic [KB-1:0]           r_i;
    logic [KB-1:0]           r_j;
    logic [RB-1:0]           r_r;
    logic [CB-1:0]           r_c;
    logic signed [OUTW-1:0]  r_acc;
    logic                    r_rd_vld;
    logic                    r_cf;

    logic                    w_k_ok;
    logic [KB-1:0]           w_kmax;
    logic                    w_ij_last;
    logic                    w_c_last;
    logic                    w_r_last;
    logic                    w_pos_last;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [OUTW:0]           w_fifo_dout;
    logic signed [PW-1:0]    w_prod;
    logic signed [OUTW-1:0]  w_prod_ext;
    logic signed [OUTW-1:0]  w_bias_ext;

    assign w_k_ok     = (K != '0) && (int'(K) <= MINRC);
    assign w_kmax     = K - KB'(1);
    assign w_ij_last  = (r_i == w_kmax) && (r_j == w_kmax);
    assign w_c_last   = (int'(r_c) == C - int'(K));
    assign w_r_last   = (int'(r_r) == R - int'(K));
    assign w_pos_last = w_r_last && w_c_last;

    assign w_prod     = PW'(X_data) * PW'(W_data);
    assign w_prod_ext = OUTW'(w_prod);
    assign w_bias_ext = OUTW'(B);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cf    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cf    <= (w_next == FINISH);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (inputs_loaded) w_next = w_k_ok ? MAC : FINISH;
            MAC:     if (w_ij_last) w_next = DRAIN;
            DRAIN:   w_next = PUSH;
            PUSH:    if (!w_fifo_full) w_next = w_pos_last ? WAIT : MAC;
            WAIT:    if (w_fifo_empty) w_next = FINISH;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        X_read_addr = '0;
        W_read_addr = '0;
        w_push      = 1'b0;
        if (r_state == MAC) begin
            X_read_addr = XA'((int'(r_r) + int'(r_i)) * C + int'(r_c) + int'(r_j));
            W_read_addr = WA'(int'(r_i) * int'(K) + int'(r_j));
        end
        if (r_state == PUSH && !w_fifo_full) w_push = 1'b1;
    end

    // Window counters step in MAC; the output position steps only when a result lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i <= '0;
            r_j <= '0;
            r_r <= '0;
            r_c <= '0;
        end else begin
            if (r_state == MAC) begin
                if (r_j == w_kmax) begin
                    r_j <= '0;
                    r_i <= (r_i == w_kmax) ? '0 : r_i + KB'(1);
                end else begin
                    r_j <= r_j + KB'(1);
                end
            end
            if (w_push) begin
                if (w_c_last) begin
                    r_c <= '0;
                    r_r <= w_r_last ? '0 : r_r + RB'(1);
                end else begin
                    r_c <= r_c + CB'(1);
                end
            end
        end
    end

    // Seed with the bias on MAC entry; r_rd_vld marks cycles whose memory data belongs to the window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= (r_state == MAC);
            if (w_next == MAC && r_state != MAC) r_acc <= w_bias_ext;
            else if (r_rd_vld)                   r_acc <= r_acc + w_prod_ext;
        end
    end

    output_fifo #(
        .WIDTH (OUTW + 1),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst_n    (reset_n),
        .push     (w_push),
        .data_in  ({w_pos_last, r_acc}),
        .full     (w_fifo_full),
        .pop      (w_pop),
        .data_out (w_fifo_dout),
        .empty    (w_fifo_empty)
    );

    assign w_pop            = OUT_AXIS_TVALID & OUT_AXIS_TREADY;
    assign OUT_AXIS_TVALID  = ~w_fifo_empty;
    assign OUT_AXIS_TDATA   = w_fifo_dout[OUTW-1:0];
    assign OUT_AXIS_TLAST   = w_fifo_dout[OUTW];
    assign compute_finished = r_cf;

endmodule
